rn_busytable_ckpt: RTL and testbench

- Physical-register busy table for the rename stage, with multi-port allocate/writeback and checkpoint/restore for branch-mispredict recovery.
- Tracks one busy bit per PRF entry. Rename sets the bit on allocation; writeback clears it.
- Keeps a bank of snapshots so a mispredicted branch restores the busy state in one cycle.
- Provides issue-side source-ready lookups with same-cycle writeback bypass.

---
 rtl/rn_busytable_ckpt_if.sv | 45 ++++
 rtl/rn_busytable_ckpt.sv | 98 +++++++++
 tb/tb_rn_busytable_ckpt.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/rn_busytable_ckpt_if.sv
// Rename-side bus of the busy table: allocate, writeback, checkpoint control,
// source-ready lookups and the registered status outputs.
interface rn_busytable_ckpt_if #(
  parameter int CONFIG_P_ISSUE_WIDTH     = 1,
  parameter int CONFIG_P_WRITEBACK_WIDTH = 1,
  parameter int CONFIG_PRF_AW            = 6,
  parameter int CONFIG_P_NUM_CKPT        = 2,
  parameter int CONFIG_NUM_RD            = 4
);
  localparam int IW = 1 << CONFIG_P_ISSUE_WIDTH;
  localparam int WW = 1 << CONFIG_P_WRITEBACK_WIDTH;
  localparam int AW = CONFIG_PRF_AW;
  localparam int NP = 1 << CONFIG_PRF_AW;
  localparam int NC = 1 << CONFIG_P_NUM_CKPT;
  localparam int CW = CONFIG_P_NUM_CKPT;
  localparam int NR = CONFIG_NUM_RD;

  logic              flush;
  logic [IW*AW-1:0]  prd;
  logic [IW-1:0]     prd_we;
  logic [WW*AW-1:0]  prf_WADDR;
  logic [WW-1:0]     prf_WE;
  logic              ckpt_we;
  logic [CW-1:0]     ckpt_id;
  logic [NC-1:0]     ckpt_release;
  logic              rec_valid;
  logic [CW-1:0]     rec_id;
  logic [NR*AW-1:0]  rs_addr;
  logic [NR-1:0]     rs_busy;
  logic [NP-1:0]     busytable;
  logic [NC-1:0]     ckpt_vld;
  logic              rec_err;

  modport master (
    output flush, prd, prd_we, prf_WADDR, prf_WE, ckpt_we, ckpt_id,
           ckpt_release, rec_valid, rec_id, rs_addr,
    input  rs_busy, busytable, ckpt_vld, rec_err
  );

  modport slave (
    input  flush, prd, prd_we, prf_WADDR, prf_WE, ckpt_we, ckpt_id,
           ckpt_release, rec_valid, rec_id, rs_addr,
    output rs_busy, busytable, ckpt_vld, rec_err
  );
endinterface

// File: rtl/rn_busytable_ckpt.sv
// Physical-register busy table with multi-port allocate/writeback, a bank of
// snapshots for single-cycle mispredict recovery, and bypassed ready lookups.
module rn_busytable_ckpt #(
  parameter int CONFIG_P_ISSUE_WIDTH     = 1,
  parameter int CONFIG_P_WRITEBACK_WIDTH = 1,
  parameter int CONFIG_PRF_AW            = 6,
  parameter int CONFIG_P_NUM_CKPT        = 2,
  parameter int CONFIG_NUM_RD            = 4
) (
  input logic clk,
  input logic rst,
  rn_busytable_ckpt_if.slave bus
);
  localparam int IW = 1 << CONFIG_P_ISSUE_WIDTH;
  localparam int WW = 1 << CONFIG_P_WRITEBACK_WIDTH;
  localparam int AW = CONFIG_PRF_AW;
  localparam int NP = 1 << CONFIG_PRF_AW;
  localparam int NC = 1 << CONFIG_P_NUM_CKPT;
  localparam int NR = CONFIG_NUM_RD;

  logic [NP-1:0] busy_q, busy_d;
  logic [NP-1:0] ckpt_q [NC];
  logic [NP-1:0] ckpt_d [NC];
  logic [NC-1:0] vld_q, vld_d;
  logic          err_q, err_d;

  logic [NP-1:0] wb_clr;
  logic [NP-1:0] alloc_set;
  logic [NP-1:0] norm_upd;
  logic          rec_ok;
  logic          snap;

  // Decode writeback clears and allocate sets; entry 0 can never become busy.
  always_comb begin
    wb_clr    = '0;
    alloc_set = '0;
    for (int w = 0; w < WW; w++) begin
      if (bus.prf_WE[w]) wb_clr[bus.prf_WADDR[w*AW +: AW]] = 1'b1;
    end
    for (int s = 0; s < IW; s++) begin
      if (bus.prd_we[s]) alloc_set[bus.prd[s*AW +: AW]] = 1'b1;
    end
    alloc_set[0] = 1'b0;
    norm_upd     = (busy_q & ~wb_clr) | alloc_set;
  end

  assign rec_ok = vld_q[bus.rec_id];
  assign snap   = bus.ckpt_we & ~bus.rec_valid & ~bus.flush;

  always_comb begin
    busy_d = norm_upd;
    err_d  = 1'b0;
    vld_d  = vld_q & ~bus.ckpt_release;
    if (bus.flush) begin
      busy_d = '0;
      vld_d  = '0;
    end else if (bus.rec_valid) begin
      // A failed restore still retires this cycle's writebacks but drops the allocations.
      busy_d = rec_ok ? (ckpt_q[bus.rec_id] & ~wb_clr) : (busy_q & ~wb_clr);
      err_d  = ~rec_ok;
    end else if (snap) begin
      vld_d[bus.ckpt_id] = 1'b1;
    end
  end

  // Completed registers are cleared from every timeline, valid slot or not.
  always_comb begin
    for (int c = 0; c < NC; c++) begin
      ckpt_d[c] = ckpt_q[c] & ~wb_clr;
      if (snap && (bus.ckpt_id == c[$bits(bus.ckpt_id)-1:0])) ckpt_d[c] = norm_upd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      vld_q  <= '0;
      err_q  <= 1'b0;
      for (int c = 0; c < NC; c++) ckpt_q[c] <= '0;
    end else begin
      busy_q <= busy_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
      for (int c = 0; c < NC; c++) ckpt_q[c] <= ckpt_d[c];
    end
  end

  // Same-cycle writeback bypass on the lookup path; no allocate bypass.
  always_comb begin
    for (int r = 0; r < NR; r++) begin
      bus.rs_busy[r] = busy_q[bus.rs_addr[r*AW +: AW]] & ~wb_clr[bus.rs_addr[r*AW +: AW]];
    end
  end

  assign bus.busytable = busy_q;
  assign bus.ckpt_vld  = vld_q;
  assign bus.rec_err   = err_q;
endmodule

// File: tb/tb_rn_busytable_ckpt.sv
// Scoreboard bench for rn_busytable_ckpt: directed scenarios followed by a
// randomized phase checked against a behavioural reference model.
module tb_rn_busytable_ckpt;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rn_busytable_ckpt_if bif ();

  rn_busytable_ckpt dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  typedef struct {
    string       tag;
    logic [63:0] bt;
    logic [3:0]  vld;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  logic [63:0] m_bt;
  logic [63:0] m_ck [4];
  logic [3:0]  m_vld;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic clear_in();
    bif.flush        = 1'b0;
    bif.prd          = '0;
    bif.prd_we       = '0;
    bif.prf_WADDR    = '0;
    bif.prf_WE       = '0;
    bif.ckpt_we      = 1'b0;
    bif.ckpt_id      = '0;
    bif.ckpt_release = '0;
    bif.rec_valid    = 1'b0;
    bif.rec_id       = '0;
    bif.rs_addr      = '0;
  endtask

  task automatic set_alloc(input logic [5:0] a0, input logic [5:0] a1, input logic [1:0] we);
    bif.prd    = {a1, a0};
    bif.prd_we = we;
  endtask

  task automatic set_wb(input logic [5:0] w0, input logic [5:0] w1, input logic [1:0] we);
    bif.prf_WADDR = {w1, w0};
    bif.prf_WE    = we;
  endtask

  // Push the expectation for the coming edge, then pop and compare after it.
  task automatic go(input string tag, input logic [63:0] bt, input logic [3:0] vld, input logic err);
    exp_t e;
    e.tag = tag; e.bt = bt; e.vld = vld; e.err = err;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    check_eq({tag, "_sbdepth"}, 64'(sbq.size()), 64'd1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      check_eq({e.tag, "_busytable"}, bif.busytable, e.bt);
      check_eq({e.tag, "_ckpt_vld"}, 64'(bif.ckpt_vld), 64'(e.vld));
      check_eq({e.tag, "_rec_err"}, 64'(bif.rec_err), 64'(e.err));
    end
    @(negedge clk);
    clear_in();
  endtask

  function automatic logic [63:0] bm(input int a);
    logic [63:0] v;
    v = 64'd1 << a;
    return v;
  endfunction

  initial begin
    clear_in();
    @(negedge clk);
    rst = 1'b1;
    go("reset", 64'd0, 4'd0, 1'b0);
    rst = 1'b0;

    // Allocate 5 and 9, then look up 5.
    set_alloc(6'd5, 6'd9, 2'b11);
    go("alloc_5_9", bm(5) | bm(9), 4'd0, 1'b0);
    bif.rs_addr[0 +: 6] = 6'd5;
    #1 check_eq("rs_busy_5", 64'(bif.rs_busy[0]), 64'd1);

    set_alloc(6'd7, 6'd0, 2'b01);
    go("alloc_7", bm(5) | bm(9) | bm(7), 4'd0, 1'b0);
    set_wb(6'd7, 6'd0, 2'b01);
    bif.rs_addr[0 +: 6] = 6'd7;
    #1 check_eq("rs_bypass_7", 64'(bif.rs_busy[0]), 64'd0);
    go("wb_7", bm(5) | bm(9), 4'd0, 1'b0);

    // Allocate beats writeback on 12; allocate to entry 0 is dropped.
    set_alloc(6'd12, 6'd0, 2'b11);
    set_wb(6'd12, 6'd12, 2'b11);
    go("alloc_wb_12", bm(5) | bm(9) | bm(12), 4'd0, 1'b0);
    bif.rs_addr[6 +: 6] = 6'd0;
    bif.rs_addr[12 +: 6] = 6'd12;
    #1 check_eq("rs_busy_0", 64'(bif.rs_busy[1]), 64'd0);
    check_eq("rs_busy_12", 64'(bif.rs_busy[2]), 64'd1);

    bif.flush = 1'b1;
    go("flush_a", 64'd0, 4'd0, 1'b0);

    // Snapshot / restore scenario.
    set_alloc(6'd3, 6'd4, 2'b11);
    go("alloc_3_4", bm(3) | bm(4), 4'd0, 1'b0);
    set_alloc(6'd6, 6'd0, 2'b01);
    bif.ckpt_we = 1'b1; bif.ckpt_id = 2'd2;
    go("snap2", bm(3) | bm(4) | bm(6), 4'b0100, 1'b0);
    set_alloc(6'd8, 6'd0, 2'b01);
    set_wb(6'd4, 6'd4, 2'b10);
    go("alloc8_wb4", bm(3) | bm(6) | bm(8), 4'b0100, 1'b0);
    set_alloc(6'd10, 6'd0, 2'b01);
    bif.rec_valid = 1'b1; bif.rec_id = 2'd2;
    go("restore2", bm(3) | bm(6), 4'b0100, 1'b0);

    // Restore from a released (invalid) slot.
    bif.ckpt_release = 4'b0010;
    go("release1", bm(3) | bm(6), 4'b0100, 1'b0);
    set_alloc(6'd20, 6'd0, 2'b01);
    set_wb(6'd3, 6'd0, 2'b01);
    bif.rec_valid = 1'b1; bif.rec_id = 2'd1;
    go("restore_bad", bm(6), 4'b0100, 1'b1);
    go("err_drop", bm(6), 4'b0100, 1'b0);

    // Flush dominates restore, snapshot and allocate.
    set_alloc(6'd2, 6'd11, 2'b11);
    set_wb(6'd6, 6'd0, 2'b01);
    bif.ckpt_we = 1'b1; bif.ckpt_id = 2'd0;
    go("snap0", bm(2) | bm(11), 4'b0101, 1'b0);
    bif.ckpt_we = 1'b1; bif.ckpt_id = 2'd3;
    go("snap3", bm(2) | bm(11), 4'b1101, 1'b0);
    bif.ckpt_we = 1'b1; bif.ckpt_id = 2'd1; bif.ckpt_release = 4'b0010;
    go("snap_beats_rel", bm(2) | bm(11), 4'b1111, 1'b0);
    set_alloc(6'd13, 6'd0, 2'b01);
    bif.flush = 1'b1; bif.rec_valid = 1'b1; bif.rec_id = 2'd0;
    bif.ckpt_we = 1'b1; bif.ckpt_id = 2'd2;
    go("flush_all", 64'd0, 4'd0, 1'b0);
    bif.rec_valid = 1'b1; bif.rec_id = 2'd0;
    go("restore_after_flush", 64'd0, 4'd0, 1'b1);

    // Randomized phase against the reference model.
    rst = 1'b1;
    go("reset2", 64'd0, 4'd0, 1'b0);
    rst = 1'b0;
    m_bt = '0; m_vld = '0;
    for (int c = 0; c < 4; c++) m_ck[c] = '0;
    for (int n = 0; n < 300; n++) begin
      logic [63:0] wbm, alm, norm, nbt;
      logic [3:0]  nvld;
      logic        nerr;
      int          a;
      set_alloc(6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      set_wb(6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      bif.ckpt_we      = ($urandom_range(0, 3) == 0);
      bif.ckpt_id      = 2'($urandom_range(0, 3));
      bif.ckpt_release = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      bif.rec_valid    = ($urandom_range(0, 7) == 0);
      bif.rec_id       = 2'($urandom_range(0, 3));
      bif.flush        = ($urandom_range(0, 31) == 0);
      for (int r = 0; r < 4; r++) bif.rs_addr[r*6 +: 6] = 6'($urandom_range(0, 15));
      #1;
      wbm = '0; alm = '0;
      for (int p = 0; p < 2; p++) begin
        if (bif.prf_WE[p]) wbm[bif.prf_WADDR[p*6 +: 6]] = 1'b1;
        if (bif.prd_we[p] && bif.prd[p*6 +: 6] != 6'd0) alm[bif.prd[p*6 +: 6]] = 1'b1;
      end
      for (int r = 0; r < 4; r++) begin
        a = int'(bif.rs_addr[r*6 +: 6]);
        check_eq("rnd_rs_busy", 64'(bif.rs_busy[r]), 64'(m_bt[a] && !wbm[a]));
      end
      norm = (m_bt & ~wbm) | alm;
      nerr = 1'b0;
      nvld = m_vld & ~bif.ckpt_release;
      if (bif.flush) begin
        nbt = '0; nvld = '0;
      end else if (bif.rec_valid) begin
        nbt  = m_vld[bif.rec_id] ? (m_ck[bif.rec_id] & ~wbm) : (m_bt & ~wbm);
        nerr = !m_vld[bif.rec_id];
      end else begin
        nbt = norm;
        if (bif.ckpt_we) nvld[bif.ckpt_id] = 1'b1;
      end
      for (int c = 0; c < 4; c++) m_ck[c] = m_ck[c] & ~wbm;
      if (!bif.flush && !bif.rec_valid && bif.ckpt_we) m_ck[bif.ckpt_id] = norm;
      m_bt = nbt; m_vld = nvld;
      go("rnd", nbt, nvld, nerr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
